// File: rtl/br_res_station_if.sv
// Dispatch, wakeup/flush and issue bundle for the branch reservation station.
interface br_res_station_if #(
  parameter int PHY_WIDTH = 6,
  parameter int ROB_WIDTH = 4
);
  logic                 disp_valid;
  logic                 disp_ready;
  logic [6:0]           disp_opcode;
  logic [2:0]           disp_funct3;
  logic [31:0]          disp_pc;
  logic [31:0]          disp_pc_next;
  logic [31:0]          disp_imm;
  logic [ROB_WIDTH-1:0] disp_rob_id;
  logic                 disp_rs1_valid;
  logic                 disp_rs2_valid;
  logic [PHY_WIDTH-1:0] disp_pr1_s;
  logic [PHY_WIDTH-1:0] disp_pr2_s;
  logic                 disp_pr1_rdy;
  logic                 disp_pr2_rdy;

  logic                 cdb_valid;
  logic [PHY_WIDTH-1:0] cdb_pd;
  logic                 flush;

  logic                 iss_valid;
  logic [6:0]           iss_opcode;
  logic [2:0]           iss_funct3;
  logic [31:0]          iss_pc;
  logic [31:0]          iss_pc_next;
  logic [31:0]          iss_imm;
  logic [ROB_WIDTH-1:0] iss_rob_id;
  logic                 iss_rs1_valid;
  logic                 iss_rs2_valid;
  logic [PHY_WIDTH-1:0] iss_pr1_s;
  logic [PHY_WIDTH-1:0] iss_pr2_s;

  modport master (
    output disp_valid, disp_opcode, disp_funct3, disp_pc,
           disp_pc_next, disp_imm, disp_rob_id,
           disp_rs1_valid, disp_rs2_valid,
           disp_pr1_s, disp_pr2_s, disp_pr1_rdy, disp_pr2_rdy,
           cdb_valid, cdb_pd, flush,
    input  disp_ready, iss_valid, iss_opcode, iss_funct3,
           iss_pc, iss_pc_next, iss_imm, iss_rob_id,
           iss_rs1_valid, iss_rs2_valid, iss_pr1_s, iss_pr2_s
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_funct3, disp_pc,
           disp_pc_next, disp_imm, disp_rob_id,
           disp_rs1_valid, disp_rs2_valid,
           disp_pr1_s, disp_pr2_s, disp_pr1_rdy, disp_pr2_rdy,
           cdb_valid, cdb_pd, flush,
    output disp_ready, iss_valid, iss_opcode, iss_funct3,
           iss_pc, iss_pc_next, iss_imm, iss_rob_id,
           iss_rs1_valid, iss_rs2_valid, iss_pr1_s, iss_pr2_s
  );
endinterface

// File: rtl/br_res_station.sv
// Branch/jump reservation station: CDB wakeup, age-matrix
// oldest-ready select, one registered issue per cycle.
module br_res_station #(
  parameter int NO_PHY_REGS = 64,
  parameter int PHY_WIDTH   = $clog2(NO_PHY_REGS),
  parameter int ROB_WIDTH   = 4,
  parameter int DEPTH       = 4
) (
  input logic             clk,
  input logic             rst_n,
  br_res_station_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [31:0]          pc;
    logic [31:0]          pc_next;
    logic [31:0]          imm;
    logic [ROB_WIDTH-1:0] rob_id;
    logic                 rs1_valid;
    logic                 rs2_valid;
    logic [PHY_WIDTH-1:0] pr1_s;
    logic [PHY_WIDTH-1:0] pr2_s;
  } entry_t;

  entry_t           ent [DEPTH];
  entry_t           iss_q;
  entry_t           new_ent;
  logic             iss_valid_q;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rdy1;
  logic [DEPTH-1:0] rdy2;
  // age[i][j] set: entry j is older than entry i
  logic [DEPTH-1:0] age [DEPTH];

  logic [DEPTH-1:0] cand;
  logic             sel_hit;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    free_idx;
  logic             alloc;
  logic             new_rdy1;
  logic             new_rdy2;

  assign cand = valid & rdy1 & rdy2;
  assign bus.disp_ready = |(~valid);
  assign alloc = bus.disp_valid && bus.disp_ready;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && !(|(age[i] & cand))) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    new_ent.opcode    = bus.disp_opcode;
    new_ent.funct3    = bus.disp_funct3;
    new_ent.pc        = bus.disp_pc;
    new_ent.pc_next   = bus.disp_pc_next;
    new_ent.imm       = bus.disp_imm;
    new_ent.rob_id    = bus.disp_rob_id;
    new_ent.rs1_valid = bus.disp_rs1_valid;
    new_ent.rs2_valid = bus.disp_rs2_valid;
    new_ent.pr1_s     = bus.disp_pr1_s;
    new_ent.pr2_s     = bus.disp_pr2_s;
  end

  // a tag broadcast in the dispatch cycle must be caught here
  assign new_rdy1 = !bus.disp_rs1_valid
                 || (bus.disp_pr1_s == '0)
                 || bus.disp_pr1_rdy
                 || (bus.cdb_valid
                     && bus.cdb_pd == bus.disp_pr1_s);
  assign new_rdy2 = !bus.disp_rs2_valid
                 || (bus.disp_pr2_s == '0)
                 || bus.disp_pr2_rdy
                 || (bus.cdb_valid
                     && bus.cdb_pd == bus.disp_pr2_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= '0;
      rdy1        <= '0;
      rdy2        <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
        ent[i] <= '0;
      end
    end else if (bus.flush) begin
      valid       <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_valid && valid[i]) begin
          if (ent[i].pr1_s == bus.cdb_pd) rdy1[i] <= 1'b1;
          if (ent[i].pr2_s == bus.cdb_pd) rdy2[i] <= 1'b1;
        end
      end
      iss_valid_q <= sel_hit;
      iss_q       <= ent[sel_idx];
      if (sel_hit) valid[sel_idx] <= 1'b0;
      if (alloc) begin
        // stale column bits from the slot's previous owner go away
        for (int i = 0; i < DEPTH; i++) begin
          age[i][free_idx] <= 1'b0;
        end
        age[free_idx]  <= valid;
        valid[free_idx] <= 1'b1;
        ent[free_idx]  <= new_ent;
        rdy1[free_idx] <= new_rdy1;
        rdy2[free_idx] <= new_rdy2;
      end
    end
  end

  assign bus.iss_valid     = iss_valid_q;
  assign bus.iss_opcode    = iss_q.opcode;
  assign bus.iss_funct3    = iss_q.funct3;
  assign bus.iss_pc        = iss_q.pc;
  assign bus.iss_pc_next   = iss_q.pc_next;
  assign bus.iss_imm       = iss_q.imm;
  assign bus.iss_rob_id    = iss_q.rob_id;
  assign bus.iss_rs1_valid = iss_q.rs1_valid;
  assign bus.iss_rs2_valid = iss_q.rs2_valid;
  assign bus.iss_pr1_s     = iss_q.pr1_s;
  assign bus.iss_pr2_s     = iss_q.pr2_s;
endmodule

// File: tb/tb_br_res_station.sv
// Scoreboard bench for br_res_station: directed dispatch/wakeup
// sequences, issue order checked by a decoupled monitor.
module tb_br_res_station;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_res_station_if #(.PHY_WIDTH(6), .ROB_WIDTH(4)) bus ();

  br_res_station #(
    .NO_PHY_REGS(64), .PHY_WIDTH(6),
    .ROB_WIDTH(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67;

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  rob;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int passed = 0;
  int total = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", n, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.iss_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_issue: got rob %0d, want none",
                 bus.iss_rob_id);
      end else begin
        e = q.pop_front();
        chk("iss_rob", 32'(bus.iss_rob_id), 32'(e.rob));
        chk("iss_imm", bus.iss_imm, e.imm);
        chk("iss_pc", bus.iss_pc, e.pc);
        chk("iss_op", 32'(bus.iss_opcode), 32'(e.op));
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive(logic [6:0] op, logic [3:0] rob,
                       logic [31:0] pc, logic [31:0] imm,
                       logic r1v, logic [5:0] p1, logic p1r,
                       logic r2v, logic [5:0] p2, logic p2r);
    bus.disp_valid     = 1'b1;
    bus.disp_opcode    = op;
    bus.disp_funct3    = 3'd0;
    bus.disp_pc        = pc;
    bus.disp_pc_next   = pc + 32'd4;
    bus.disp_imm       = imm;
    bus.disp_rob_id    = rob;
    bus.disp_rs1_valid = r1v;
    bus.disp_pr1_s     = p1;
    bus.disp_pr1_rdy   = p1r;
    bus.disp_rs2_valid = r2v;
    bus.disp_pr2_s     = p2;
    bus.disp_pr2_rdy   = p2r;
  endtask

  task automatic cdb(logic [5:0] tag);
    bus.cdb_valid = 1'b1;
    bus.cdb_pd    = tag;
  endtask

  task automatic expect_iss(logic [6:0] op, logic [3:0] rob,
                            logic [31:0] pc, logic [31:0] imm);
    exp_t x;
    x.op = op; x.rob = rob; x.pc = pc; x.imm = imm;
    q.push_back(x);
  endtask

  initial begin
    idle();
    drive(OP_BR, 4'd0, 32'd0, 32'd0, 1'b0, 6'd0, 1'b0,
          1'b0, 6'd0, 1'b0);
    bus.disp_valid = 1'b0;
    bus.cdb_pd = 6'd0;
    step(2);
    chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst_iss_rob", 32'(bus.iss_rob_id), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);

    // simple jal, no sources
    expect_iss(OP_JAL, 4'd3, 32'h1000, 32'h20);
    drive(OP_JAL, 4'd3, 32'h1000, 32'h20, 1'b0, 6'd0, 1'b0,
          1'b0, 6'd0, 1'b0);
    step(); idle();
    chk("simple_early", 32'(bus.iss_valid), 32'd0);
    step();
    chk("simple_issue", 32'(bus.iss_valid), 32'd1);
    step();
    chk("simple_done", 32'(bus.iss_valid), 32'd0);

    // age order: B woken first issues first
    expect_iss(OP_BR, 4'd2, 32'h2010, 32'h44);
    expect_iss(OP_BR, 4'd1, 32'h2000, 32'h40);
    drive(OP_BR, 4'd1, 32'h2000, 32'h40, 1'b1, 6'd5, 1'b0,
          1'b0, 6'd0, 1'b0);
    step();
    drive(OP_BR, 4'd2, 32'h2010, 32'h44, 1'b1, 6'd6, 1'b0,
          1'b0, 6'd0, 1'b0);
    step(); idle();
    cdb(6'd6); step();
    cdb(6'd5); step();
    idle(); step(3);

    // older entry in higher slot wins a joint wakeup
    expect_iss(OP_BR, 4'd6, 32'h2100, 32'h4);
    expect_iss(OP_BR, 4'd5, 32'h2200, 32'h8);
    expect_iss(OP_BR, 4'd4, 32'h2300, 32'hc);
    drive(OP_BR, 4'd6, 32'h2100, 32'h4, 1'b1, 6'd20, 1'b0,
          1'b0, 6'd0, 1'b0);
    step();
    drive(OP_BR, 4'd5, 32'h2200, 32'h8, 1'b1, 6'd12, 1'b0,
          1'b0, 6'd0, 1'b0);
    step(); idle();
    cdb(6'd20); step(); idle(); step(2);
    drive(OP_BR, 4'd4, 32'h2300, 32'hc, 1'b0, 6'd0, 1'b0,
          1'b1, 6'd12, 1'b0);
    step(); idle();
    cdb(6'd12); step(); idle();
    step(4);

    // two sources woken by one broadcast
    expect_iss(OP_BR, 4'd7, 32'h2400, 32'h10);
    drive(OP_BR, 4'd7, 32'h2400, 32'h10, 1'b1, 6'd14, 1'b0,
          1'b1, 6'd14, 1'b0);
    step(); idle();
    cdb(6'd14); step(); idle();
    chk("wake_no_bypass", 32'(bus.iss_valid), 32'd0);
    step();
    chk("wake_issue", 32'(bus.iss_valid), 32'd1);
    step();

    // same-edge capture
    expect_iss(OP_JALR, 4'd8, 32'h3000, 32'h8);
    drive(OP_JALR, 4'd8, 32'h3000, 32'h8, 1'b1, 6'd9, 1'b0,
          1'b0, 6'd0, 1'b0);
    cdb(6'd9);
    step(); idle(); step();
    chk("same_edge_issue", 32'(bus.iss_valid), 32'd1);
    step();

    // fill, reject a fifth, free one by wakeup
    for (int i = 0; i < 4; i++) begin
      drive(OP_BR, 4'(9 + i), 32'h4000 + 32'(16 * i),
            32'(4 * i), 1'b1, 6'(30 + i), 1'b0,
            1'b0, 6'd0, 1'b0);
      step();
    end
    idle();
    chk("full_ready", 32'(bus.disp_ready), 32'd0);
    drive(OP_JAL, 4'd13, 32'h4800, 32'h0, 1'b0, 6'd0, 1'b0,
          1'b0, 6'd0, 1'b0);
    step(); idle();
    chk("full_still", 32'(bus.disp_ready), 32'd0);
    expect_iss(OP_BR, 4'd10, 32'h4010, 32'h4);
    cdb(6'd31); step(); idle();
    chk("full_wake_ready", 32'(bus.disp_ready), 32'd0);
    chk("full_wake_iss", 32'(bus.iss_valid), 32'd0);
    step();
    chk("full_after_issue", 32'(bus.disp_ready), 32'd1);
    chk("full_iss_valid", 32'(bus.iss_valid), 32'd1);

    // flush with 3 valid, issue live, dispatch and CDB hit
    bus.flush = 1'b1;
    drive(OP_JAL, 4'd14, 32'h5000, 32'h0, 1'b0, 6'd0, 1'b0,
          1'b0, 6'd0, 1'b0);
    cdb(6'd30);
    step(); idle();
    chk("flush_iss", 32'(bus.iss_valid), 32'd0);
    chk("flush_ready", 32'(bus.disp_ready), 32'd1);
    cdb(6'd30); step();
    cdb(6'd32); step();
    cdb(6'd33); step();
    idle(); step(3);
    chk("flush_no_issue", 32'(bus.iss_valid), 32'd0);

    // async reset with 3 valid and issue live
    for (int i = 0; i < 3; i++) begin
      drive(OP_BR, 4'(1 + i), 32'h6000, 32'h0, 1'b1,
            6'(40 + i), 1'b0, 1'b0, 6'd0, 1'b0);
      step();
    end
    expect_iss(OP_JAL, 4'd15, 32'h6100, 32'h10);
    drive(OP_JAL, 4'd15, 32'h6100, 32'h10, 1'b0, 6'd0, 1'b0,
          1'b0, 6'd0, 1'b0);
    step(); idle(); step();
    chk("pre_rst_iss", 32'(bus.iss_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_iss", 32'(bus.iss_valid), 32'd0);
    chk("rst_async_ready", 32'(bus.disp_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_rel_iss", 32'(bus.iss_valid), 32'd0);
    chk("rst_rel_ready", 32'(bus.disp_ready), 32'd1);
    cdb(6'd40); step();
    cdb(6'd41); step();
    cdb(6'd42); step();
    idle(); step(3);
    chk("rst_no_issue", 32'(bus.iss_valid), 32'd0);

    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
